// File: rtl/ud_count_arbiter_pkg.sv
// Shared types and helpers for the round-robin modulo up/down counter.
// Holds the FSM state enum, default modulus/width and the wrap arithmetic.
package ud_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam int DEF_MOD = 12;
    localparam int DEF_CW  = 4;

    // Single modulo step; count is assumed to be already in 0..mod-1.
    function automatic int unsigned next_count(
        input int unsigned count,
        input logic        up,
        input int unsigned mod
    );
        if (up) begin
            return (count == mod - 1) ? 0 : count + 1;
        end
        return (count == 0) ? mod - 1 : count - 1;
    endfunction

endpackage

// File: rtl/ud_count_arbiter_if.sv
// Requester-side bundle of the shared counter: req/dir in, gnt/Count/flags out.
// master = requesters, slave = arbiter. wrap_cnt exists only with UDC_WRAP_CNT_EN.
interface ud_count_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CW      = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] dir;
    logic [NUM_REQ-1:0] gnt;
    logic [CW-1:0]      Count;
    logic               wrap_up;
    logic               wrap_dn;
    logic               busy;
`ifdef UDC_WRAP_CNT_EN
    logic [7:0]         wrap_cnt;

    modport master (
        output req, dir,
        input  gnt, Count, wrap_up, wrap_dn, busy, wrap_cnt
    );
    modport slave (
        input  req, dir,
        output gnt, Count, wrap_up, wrap_dn, busy, wrap_cnt
    );
`else
    modport master (
        output req, dir,
        input  gnt, Count, wrap_up, wrap_dn, busy
    );
    modport slave (
        input  req, dir,
        output gnt, Count, wrap_up, wrap_dn, busy
    );
`endif
endinterface

// File: rtl/ud_rr_pick.sv
// Combinational round-robin selector: first set req bit from ptr upward.
// Ports: req (vector), ptr (start index) -> valid, winner (index).
module ud_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic               valid,
    output logic [PW-1:0]      winner
);
    logic [PW-1:0] idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PW'((32'(ptr) + 32'(i)) % NUM_REQ);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/ud_count_arbiter.sv
// Round-robin arbiter sharing one modulo-MOD up/down count among NUM_REQ agents.
// Ports: Clk, reset (sync, active-high), bus (slave: req/dir in; gnt/Count/
// wrap_up/wrap_dn/busy out). Define UDC_WRAP_CNT_EN for the saturating wrap_cnt.
module ud_count_arbiter
    import ud_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MOD     = DEF_MOD,
    parameter int CW      = DEF_CW
) (
    input  logic                  Clk,
    input  logic                  reset,
    ud_count_arbiter_if.slave     bus
);
    localparam int PW = $clog2(NUM_REQ);

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_q, win_d;
    logic          up_q, up_d;
    logic [CW-1:0] count_q, count_d;
    logic          wrap_up_q, wrap_up_d;
    logic          wrap_dn_q, wrap_dn_d;
`ifdef UDC_WRAP_CNT_EN
    logic [7:0]    wrap_cnt_q, wrap_cnt_d;
`endif

    logic          pick_valid;
    logic [PW-1:0] pick_win;
    logic [NUM_REQ-1:0] gnt;

    ud_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .winner (pick_win)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        up_d      = up_q;
        count_d   = count_q;
        wrap_up_d = 1'b0;
        wrap_dn_d = 1'b0;
        gnt       = '0;
`ifdef UDC_WRAP_CNT_EN
        wrap_cnt_d = wrap_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d   = pick_win;
                    up_d    = bus.dir[pick_win];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                gnt[win_q] = 1'b1;
                count_d    = CW'(next_count(32'(count_q), up_q, MOD));
                // Flags are registered so they line up with the new Count.
                wrap_up_d  = up_q && (count_q == CW'(MOD - 1));
                wrap_dn_d  = !up_q && (count_q == '0);
                ptr_d      = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef UDC_WRAP_CNT_EN
        if ((wrap_up_d || wrap_dn_d) && (wrap_cnt_q != 8'hFF)) begin
            wrap_cnt_d = wrap_cnt_q + 8'd1;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            up_q      <= 1'b0;
            count_q   <= '0;
            wrap_up_q <= 1'b0;
            wrap_dn_q <= 1'b0;
`ifdef UDC_WRAP_CNT_EN
            wrap_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            up_q      <= up_d;
            count_q   <= count_d;
            wrap_up_q <= wrap_up_d;
            wrap_dn_q <= wrap_dn_d;
`ifdef UDC_WRAP_CNT_EN
            wrap_cnt_q <= wrap_cnt_d;
`endif
        end
    end

    assign bus.gnt     = gnt;
    assign bus.busy    = (state_q == EXEC);
    assign bus.Count   = count_q;
    assign bus.wrap_up = wrap_up_q;
    assign bus.wrap_dn = wrap_dn_q;
`ifdef UDC_WRAP_CNT_EN
    assign bus.wrap_cnt = wrap_cnt_q;
`endif

endmodule
